// File: rtl/morse_tx_core.sv
// Morse letter transmitter: takes a length plus a left-aligned dot/dash pattern on a start
// handshake and plays it on a registered LED, with symbol gaps, a trailing letter gap and done/err pulses.
module morse_tx_core #(
  parameter int DOT_CYCLES = 25_000_000,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 3,
  parameter int MAX_LEN    = 5,
  parameter int LEN_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   code_len,
  input  logic [MAX_LEN-1:0] code_bits,
  output logic               ready,
  output logic               busy,
  output logic               led,
  output logic               done,
  output logic               err,
  output logic [LEN_W-1:0]   sym_left
);

  localparam int LONG_UNITS = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
  localparam int CNT_W      = $clog2(LONG_UNITS * DOT_CYCLES) + 1;

  // Counter holds "cycles remaining minus one", so a state loaded with N-1 lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_UNITS * DOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAIL_LOAD = CNT_W'(GAP_UNITS * DOT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ON, GAP, TAIL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [MAX_LEN-1:0] shift_next;
  logic [LEN_W-1:0]   sym_left_q, sym_left_d;
  logic               led_q, led_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               len_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      sym_left_q <= '0;
      led_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sym_left_q <= sym_left_d;
      led_q      <= led_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sym_left_d = sym_left_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    shift_next = shift_q << 1;
    len_ok     = (code_len != '0) && (int'(code_len) <= MAX_LEN);

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (len_ok) begin
            state_d    = ON;
            shift_d    = code_bits;
            sym_left_d = code_len - LEN_W'(1);
            cnt_d      = code_bits[MAX_LEN-1] ? DASH_LOAD : DOT_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ON: begin
        if (cnt_q == '0) begin
          if (sym_left_q != '0) begin
            state_d = GAP;
            cnt_d   = DOT_LOAD;
          end else begin
            state_d = TAIL;
            cnt_d   = TAIL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d    = ON;
          shift_d    = shift_next;
          sym_left_d = sym_left_q - LEN_W'(1);
          cnt_d      = shift_next[MAX_LEN-1] ? DASH_LOAD : DOT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TAIL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort drops the letter without a done pulse.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      shift_d    = '0;
      sym_left_d = '0;
      done_d     = 1'b0;
    end

    led_d = (state_d == ON);
  end

  always_comb begin
    ready    = (state_q == IDLE);
    busy     = (state_q != IDLE);
    led      = led_q;
    done     = done_q;
    err      = err_q;
    sym_left = sym_left_q;
  end

endmodule

// File: tb/tb_morse_tx_core.sv
// Scoreboard bench for morse_tx_core: each letter pushes its expected per-cycle output
// timeline into a queue, and every clock the observed outputs are compared against the popped entry.
module tb_morse_tx_core;

  localparam int DOT  = 4;
  localparam int DASH = 3;
  localparam int GAPU = 3;
  localparam int MAXL = 5;
  localparam int LW   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [LW-1:0]   code_len = '0;
  logic [MAXL-1:0] code_bits = '0;
  logic            ready, busy, led, done, err;
  logic [LW-1:0]   sym_left;

  morse_tx_core #(
    .DOT_CYCLES(DOT), .DASH_UNITS(DASH), .GAP_UNITS(GAPU), .MAX_LEN(MAXL), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .code_len(code_len), .code_bits(code_bits),
    .ready(ready), .busy(busy), .led(led), .done(done), .err(err), .sym_left(sym_left)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sb_q[$];
  string       phase = "reset";

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed {led, ready, busy, done, err, sym_left}.
  function automatic logic [7:0] pk(input bit l, input bit r, input bit d, input bit e, input int s);
    return {l, r, ~r, d, e, 3'(s)};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {led, ready, busy, done, err, sym_left};
  endfunction

  task automatic step();
    logic [7:0] exp;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else exp = pk(0, 1, 0, 0, 0);
    check_eq(phase, 32'(obs_vec()), 32'(exp));
  endtask

  task automatic push_letter(input int len, input logic [MAXL-1:0] bits);
    int dur;
    for (int i = 0; i < len; i++) begin
      dur = bits[MAXL-1-i] ? DASH * DOT : DOT;
      for (int k = 0; k < dur; k++) sb_q.push_back(pk(1, 0, 0, 0, len - 1 - i));
      if (i < len - 1)
        for (int k = 0; k < DOT; k++) sb_q.push_back(pk(0, 0, 0, 0, len - 1 - i));
    end
    for (int k = 0; k < GAPU * DOT; k++) sb_q.push_back(pk(0, 0, 0, 0, 0));
    sb_q.push_back(pk(0, 1, 1, 0, 0));
  endtask

  // Start is driven during cycle 0; poke/abort_at are the cycles in which those inputs go high.
  task automatic send(input string name, input int len, input logic [MAXL-1:0] bits,
                      input int poke, input int abort_at);
    int c;
    phase = name;
    code_len = LW'(len);
    code_bits = bits;
    start = 1'b1;
    abort = 1'b0;
    push_letter(len, bits);
    step();
    c = 1;
    start = 1'b0;
    code_len = LW'($urandom);
    code_bits = MAXL'($urandom);
    while (sb_q.size() > 0 && c < 300) begin
      start = (c == poke);
      abort = (c == abort_at);
      if (c == abort_at) begin
        sb_q.delete();
        sb_q.push_back(pk(0, 1, 0, 0, 0));
      end
      step();
      c++;
    end
    start = 1'b0;
    abort = 1'b0;
    if (sb_q.size() > 0) begin
      check_eq({name, "_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic bad_start(input string name, input int len);
    phase = name;
    code_len = LW'(len);
    code_bits = 5'b10101;
    start = 1'b1;
    sb_q.push_back(pk(0, 1, 0, 1, 0));
    step();
    start = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    #1;
    check_eq("reset_state", 32'(obs_vec()), 32'(pk(0, 1, 0, 0, 0)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    phase = "idle0";
    repeat (2) step();

    send("letter_A", 2, 5'b01000, 6, -1);
    phase = "idle_a";
    repeat (3) step();

    send("letter_E", 1, 5'b00000, -1, -1);
    send("letter_E_b2b", 1, 5'b00000, -1, -1);
    phase = "idle_e";
    repeat (2) step();

    send("digit_0", 5, 5'b11111, -1, -1);
    phase = "idle_0";
    step();

    bad_start("err_len0", 0);
    bad_start("err_len6", 6);

    phase = "abort_start_idle";
    code_len = 3'd2;
    code_bits = 5'b01000;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (3) step();

    send("abort_A", 2, 5'b01000, -1, 10);
    phase = "abort_no_done";
    repeat (4) step();

    // Letter B interrupted by reset in cycle 7, then letter D.
    phase = "letter_B";
    code_len = 3'd4;
    code_bits = 5'b10000;
    start = 1'b1;
    push_letter(4, 5'b10000);
    step();
    start = 1'b0;
    repeat (6) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'(obs_vec()), 32'(pk(0, 1, 0, 0, 0)));
    sb_q.delete();
    @(posedge clk);
    #1;
    check_eq("rst_hold", 32'(obs_vec()), 32'(pk(0, 1, 0, 0, 0)));
    #2;
    rst_n = 1'b1;
    phase = "idle_rst";
    repeat (2) step();
    send("letter_D", 3, 5'b10000, -1, -1);
    phase = "idle_end";
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
